// File: rtl/icetap_trigger_seq_pkg.sv
// Shared definitions for the icetap trigger sequencer: per-signal condition
// codes, FSM state encoding and the condition evaluation helper.
package icetap_trigger_seq_pkg;

    localparam logic [2:0] ICETAP_COND_DC   = 3'b000;
    localparam logic [2:0] ICETAP_COND_HIGH = 3'b001;
    localparam logic [2:0] ICETAP_COND_LOW  = 3'b010;
    localparam logic [2:0] ICETAP_COND_ANY  = 3'b011;
    localparam logic [2:0] ICETAP_COND_RISE = 3'b101;
    localparam logic [2:0] ICETAP_COND_FALL = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } icetap_state_e;

    // Codes 100 and 111 are unassigned and behave as don't care.
    function automatic logic cond_ok(input logic [2:0] code, input logic cur, input logic prev);
        logic ok;
        case (code)
            ICETAP_COND_DC:   ok = 1'b1;
            ICETAP_COND_HIGH: ok = cur;
            ICETAP_COND_LOW:  ok = ~cur;
            ICETAP_COND_ANY:  ok = cur ^ prev;
            ICETAP_COND_RISE: ok = cur & ~prev;
            ICETAP_COND_FALL: ok = ~cur & prev;
            default:          ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/icetap_mask_match.sv
// Combinational mask matcher: high when every signal satisfies its 3-bit
// condition code, comparing the current sample against the previous one.
module icetap_mask_match
    import icetap_trigger_seq_pkg::*;
#(
    parameter int NR_SIGNALS = 8
) (
    input  logic [NR_SIGNALS-1:0]   cur,
    input  logic [NR_SIGNALS-1:0]   prev,
    input  logic [3*NR_SIGNALS-1:0] mask,
    output logic                    match
);

    always_comb begin
        match = 1'b1;
        for (int i = 0; i < NR_SIGNALS; i++) begin
            if (!cond_ok(mask[3*i +: 3], cur[i], prev[i])) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/icetap_trigger_seq.sv
// Multi-stage trigger sequencer and capture-address engine for icetap.
// Optional per-stage timeout enabled by defining ICETAP_TRIG_TIMEOUT_EN.
module icetap_trigger_seq
    import icetap_trigger_seq_pkg::*;
#(
    parameter int NR_SIGNALS = 8,
    parameter int NR_STAGES  = 4,
    parameter int DEPTH      = 256,
    parameter int CNT_W      = 16,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int STAGE_W   = (NR_STAGES > 1) ? $clog2(NR_STAGES) : 1,
    localparam int NRS_W     = $clog2(NR_STAGES + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NR_SIGNALS-1:0]             signals_in,
    input  logic                              cmd_start,
    input  logic                              cmd_abort,
    input  logic [3*NR_SIGNALS-1:0]           cfg_store_mask,
    input  logic [NR_STAGES*3*NR_SIGNALS-1:0] cfg_trig_mask,
    input  logic [NR_STAGES*CNT_W-1:0]        cfg_trig_count,
    input  logic [NRS_W-1:0]                  cfg_nr_stages,
    input  logic [ADDR_W-1:0]                 cfg_post_len,
`ifdef ICETAP_TRIG_TIMEOUT_EN
    input  logic [CNT_W-1:0]                  cfg_stage_timeout,
`endif
    output logic                              ram_wr_en,
    output logic [ADDR_W-1:0]                 ram_wr_addr,
    output logic [NR_SIGNALS-1:0]             ram_wr_data,
    output logic [STAGE_W-1:0]                cur_stage,
    output logic                              busy,
    output logic                              triggered,
    output logic                              done,
    output logic                              full,
    output logic [ADDR_W-1:0]                 trig_addr,
    output logic [ADDR_W-1:0]                 first_addr
);

    icetap_state_e          r_state;
    icetap_state_e          w_next_state;
    logic [NR_SIGNALS-1:0]  r_signals_d;
    logic                   r_edge_ok;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [STAGE_W-1:0]     r_stage;
    logic [CNT_W-1:0]       r_occ_cnt;
    logic [ADDR_W-1:0]      r_post_cnt;
    logic                   r_triggered;
    logic                   r_full;
    logic [ADDR_W-1:0]      r_trig_addr;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr_q;
    logic [NR_SIGNALS-1:0]  r_wr_data;
`ifdef ICETAP_TRIG_TIMEOUT_EN
    logic [CNT_W-1:0]       r_to_cnt;
`endif

    logic [NR_SIGNALS-1:0]  w_prev;
    logic                   w_store_match;
    logic [NR_STAGES-1:0]   w_stage_match;
    logic                   w_cur_match;
    logic [CNT_W-1:0]       w_eff_cnt;
    logic [STAGE_W-1:0]     w_last_stage;
    logic                   w_active;
    logic                   w_start;
    logic                   w_hit;
    logic                   w_adv;
    logic                   w_trig;
    logic                   w_store;

    // Feeding the current sample as "previous" makes every edge condition
    // false on the first ARMED cycle, before a valid history exists.
    assign w_prev = r_edge_ok ? r_signals_d : signals_in;

    icetap_mask_match #(.NR_SIGNALS(NR_SIGNALS)) u_store_match (
        .cur   (signals_in),
        .prev  (w_prev),
        .mask  (cfg_store_mask),
        .match (w_store_match)
    );

    for (genvar g = 0; g < NR_STAGES; g++) begin : g_stage
        icetap_mask_match #(.NR_SIGNALS(NR_SIGNALS)) u_trig_match (
            .cur   (signals_in),
            .prev  (w_prev),
            .mask  (cfg_trig_mask[g*3*NR_SIGNALS +: 3*NR_SIGNALS]),
            .match (w_stage_match[g])
        );
    end

    assign w_cur_match = w_stage_match[r_stage];

    always_comb begin
        w_eff_cnt = cfg_trig_count[CNT_W-1:0];
        for (int k = 0; k < NR_STAGES; k++) begin
            if (r_stage == STAGE_W'(k)) begin
                w_eff_cnt = cfg_trig_count[k*CNT_W +: CNT_W];
            end
        end
        if (w_eff_cnt == '0) begin
            w_eff_cnt = CNT_W'(1);
        end
    end

    always_comb begin
        if (cfg_nr_stages == '0) begin
            w_last_stage = '0;
        end else if (cfg_nr_stages > NRS_W'(NR_STAGES)) begin
            w_last_stage = STAGE_W'(NR_STAGES - 1);
        end else begin
            w_last_stage = STAGE_W'(cfg_nr_stages - 1'b1);
        end
    end

    assign w_active = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_start  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && cmd_start && !cmd_abort;
    assign w_hit    = (r_state == ST_ARMED) && !cmd_abort && w_cur_match;
    assign w_adv    = w_hit && (({1'b0, r_occ_cnt} + 1'b1) >= {1'b0, w_eff_cnt});
    assign w_trig   = w_adv && (r_stage == w_last_stage);
    assign w_store  = w_active && !cmd_abort && (w_store_match || w_trig);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (cmd_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cmd_start) begin
                        w_next_state = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        w_next_state = (cfg_post_len == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (w_store && ((r_post_cnt + 1'b1) == cfg_post_len)) begin
                        w_next_state = ST_DONE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_signals_d <= '0;
            r_edge_ok   <= 1'b0;
            r_wr_addr   <= '0;
            r_stage     <= '0;
            r_occ_cnt   <= '0;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
            r_full      <= 1'b0;
            r_trig_addr <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr_q <= '0;
            r_wr_data   <= '0;
`ifdef ICETAP_TRIG_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            r_signals_d <= signals_in;
            r_edge_ok   <= w_active;
            r_wr_en     <= w_store;
            if (w_start) begin
                r_wr_addr   <= '0;
                r_stage     <= '0;
                r_occ_cnt   <= '0;
                r_post_cnt  <= '0;
                r_triggered <= 1'b0;
                r_full      <= 1'b0;
`ifdef ICETAP_TRIG_TIMEOUT_EN
                r_to_cnt    <= '0;
`endif
            end else begin
                if (w_store) begin
                    r_wr_addr_q <= r_wr_addr;
                    r_wr_data   <= signals_in;
                    r_wr_addr   <= r_wr_addr + 1'b1;
                    if (r_wr_addr == '1) begin
                        r_full <= 1'b1;
                    end
                end
                if (w_hit) begin
                    if (w_adv) begin
                        r_occ_cnt <= '0;
                        if (w_trig) begin
                            r_triggered <= 1'b1;
                            r_trig_addr <= r_wr_addr;
                            r_post_cnt  <= '0;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end else begin
                        r_occ_cnt <= r_occ_cnt + 1'b1;
                    end
                end
                if ((r_state == ST_POST) && w_store) begin
                    r_post_cnt <= r_post_cnt + 1'b1;
                end
`ifdef ICETAP_TRIG_TIMEOUT_EN
                // Placed last so an expiring timeout overrides an occ_cnt bump.
                if ((r_state == ST_ARMED) && !cmd_abort) begin
                    if (w_adv) begin
                        r_to_cnt <= '0;
                    end else if (r_stage != '0) begin
                        if ((cfg_stage_timeout != '0) && ((r_to_cnt + 1'b1) == cfg_stage_timeout)) begin
                            r_stage   <= '0;
                            r_occ_cnt <= '0;
                            r_to_cnt  <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
`endif
            end
        end
    end

    assign ram_wr_en   = r_wr_en;
    assign ram_wr_addr = r_wr_addr_q;
    assign ram_wr_data = r_wr_data;
    assign cur_stage   = r_stage;
    assign busy        = w_active;
    assign triggered   = r_triggered;
    assign done        = (r_state == ST_DONE);
    assign full        = r_full;
    assign trig_addr   = r_trig_addr;
    assign first_addr  = r_full ? r_wr_addr : '0;

endmodule

// File: tb/tb_icetap_trigger_seq.sv
// Directed self-checking bench for icetap_trigger_seq (default DUT plus a
// DEPTH=16 instance for ring-buffer wrap).
module tb_icetap_trigger_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  signals_in;
    logic        cmd_start;
    logic        cmd_abort;
    logic [23:0] cfg_store_mask;
    logic [95:0] cfg_trig_mask;
    logic [63:0] cfg_trig_count;
    logic [2:0]  cfg_nr_stages;
    logic [7:0]  cfg_post_len;
`ifdef ICETAP_TRIG_TIMEOUT_EN
    logic [15:0] cfg_stage_timeout;
`endif

    logic        ram_wr_en_a, busy_a, triggered_a, done_a, full_a;
    logic [7:0]  ram_wr_addr_a, ram_wr_data_a, trig_addr_a, first_addr_a;
    logic [1:0]  cur_stage_a;

    logic        ram_wr_en_b, busy_b, triggered_b, done_b, full_b;
    logic [3:0]  ram_wr_addr_b, trig_addr_b, first_addr_b;
    logic [7:0]  ram_wr_data_b;
    logic [1:0]  cur_stage_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    logic [1:0] stage_hist[0:511];
    int         last_k;

    always #5 clk = ~clk;

    icetap_trigger_seq dut_a (
        .clk            (clk),
        .reset          (reset),
        .signals_in     (signals_in),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .cfg_store_mask (cfg_store_mask),
        .cfg_trig_mask  (cfg_trig_mask),
        .cfg_trig_count (cfg_trig_count),
        .cfg_nr_stages  (cfg_nr_stages),
        .cfg_post_len   (cfg_post_len),
`ifdef ICETAP_TRIG_TIMEOUT_EN
        .cfg_stage_timeout (cfg_stage_timeout),
`endif
        .ram_wr_en      (ram_wr_en_a),
        .ram_wr_addr    (ram_wr_addr_a),
        .ram_wr_data    (ram_wr_data_a),
        .cur_stage      (cur_stage_a),
        .busy           (busy_a),
        .triggered      (triggered_a),
        .done           (done_a),
        .full           (full_a),
        .trig_addr      (trig_addr_a),
        .first_addr     (first_addr_a)
    );

    icetap_trigger_seq #(.DEPTH(16)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .signals_in     (signals_in),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .cfg_store_mask (cfg_store_mask),
        .cfg_trig_mask  (cfg_trig_mask),
        .cfg_trig_count (cfg_trig_count),
        .cfg_nr_stages  (cfg_nr_stages),
        .cfg_post_len   (cfg_post_len[3:0]),
`ifdef ICETAP_TRIG_TIMEOUT_EN
        .cfg_stage_timeout (cfg_stage_timeout),
`endif
        .ram_wr_en      (ram_wr_en_b),
        .ram_wr_addr    (ram_wr_addr_b),
        .ram_wr_data    (ram_wr_data_b),
        .cur_stage      (cur_stage_b),
        .busy           (busy_b),
        .triggered      (triggered_b),
        .done           (done_b),
        .full           (full_b),
        .trig_addr      (trig_addr_b),
        .first_addr     (first_addr_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [23:0] st, input logic [23:0] t0, input logic [23:0] t1,
                           input logic [15:0] c0, input logic [15:0] c1,
                           input logic [2:0] ns, input logic [7:0] pl);
        cfg_store_mask = st;
        cfg_trig_mask  = {48'h0, t1, t0};
        cfg_trig_count = {32'h0, c1, c0};
        cfg_nr_stages  = ns;
        cfg_post_len   = pl;
    endtask

    // stop_sel: 0 done_a, 1 done_b (logs dut_b writes), 2 triggered_a, 3 run full budget
    task automatic run_capture(input int stop_sel, input logic [7:0] sig_at_start, input int max_cyc);
        wr_addr_log.delete();
        wr_data_log.delete();
        last_k = -1;
        signals_in = sig_at_start;
        cmd_start  = 1'b1;
        tick();
        cmd_start  = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            signals_in = 8'(k);
            tick();
            if (stop_sel == 1) begin
                if (ram_wr_en_b) begin
                    wr_addr_log.push_back({4'h0, ram_wr_addr_b});
                    wr_data_log.push_back(ram_wr_data_b);
                end
            end else if (ram_wr_en_a) begin
                wr_addr_log.push_back(ram_wr_addr_a);
                wr_data_log.push_back(ram_wr_data_a);
            end
            stage_hist[k] = cur_stage_a;
            last_k = k;
            if (stop_sel == 0 && done_a) break;
            if (stop_sel == 1 && done_b) break;
            if (stop_sel == 2 && triggered_a) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        signals_in = 8'h00;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        set_cfg(24'h0, 24'h0, 24'h0, 16'h0, 16'h0, 3'd1, 8'd0);
`ifdef ICETAP_TRIG_TIMEOUT_EN
        cfg_stage_timeout = 16'd0;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (ram_wr_en_a !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", ram_wr_en_a); end
        checks++; if (ram_wr_addr_a !== 8'h00) begin errors++; $display("FAIL rst_wr_addr: got %h expected 00", ram_wr_addr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done_a); end
        checks++; if (triggered_a !== 1'b0) begin errors++; $display("FAIL rst_triggered: got %b expected 0", triggered_a); end
        checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full_a); end
        checks++; if (trig_addr_a !== 8'h00) begin errors++; $display("FAIL rst_trig_addr: got %h expected 00", trig_addr_a); end
        checks++; if (first_addr_a !== 8'h00) begin errors++; $display("FAIL rst_first_addr: got %h expected 00", first_addr_a); end
        checks++; if (cur_stage_a !== 2'd0) begin errors++; $display("FAIL rst_cur_stage: got %0d expected 0", cur_stage_a); end
    endtask

    // Store all, single stage bit7 high (count 0 behaves as 1), post 4.
    task automatic test_single_stage();
        set_cfg(24'h0, 24'h200000, 24'h0, 16'd0, 16'd0, 3'd1, 8'd4);
        run_capture(0, 8'h00, 300);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", done_a); end
        checks++; if (triggered_a !== 1'b1) begin errors++; $display("FAIL single_triggered: got %b expected 1", triggered_a); end
        checks++; if (trig_addr_a !== 8'h80) begin errors++; $display("FAIL single_trig_addr: got %h expected 80", trig_addr_a); end
        checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL single_full: got %b expected 0", full_a); end
        checks++; if (first_addr_a !== 8'h00) begin errors++; $display("FAIL single_first_addr: got %h expected 00", first_addr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy_a); end
        checks++; if (wr_addr_log.size() != 133) begin errors++; $display("FAIL single_nwrites: got %0d expected 133", wr_addr_log.size()); end
        if (wr_addr_log.size() == 133) begin
            checks++; if (wr_addr_log[128] !== 8'h80 || wr_data_log[128] !== 8'h80) begin errors++; $display("FAIL single_trig_write: got addr %h data %h expected 80/80", wr_addr_log[128], wr_data_log[128]); end
            checks++; if (wr_addr_log[132] !== 8'h84 || wr_data_log[132] !== 8'h84) begin errors++; $display("FAIL single_last_write: got addr %h data %h expected 84/84", wr_addr_log[132], wr_data_log[132]); end
        end
        signals_in = 8'h85;
        tick();
        checks++; if (ram_wr_en_a !== 1'b0) begin errors++; $display("FAIL single_no_write_done: got %b expected 0", ram_wr_en_a); end
    endtask

    // Falling edge on bit0; start cycle holds 0xFF so a falsely enabled edge
    // would fire on the first sample. Post length 0.
    task automatic test_first_edge();
        set_cfg(24'h0, 24'h000006, 24'h0, 16'd1, 16'd0, 3'd1, 8'd0);
        run_capture(0, 8'hFF, 20);
        checks++; if (trig_addr_a !== 8'h02) begin errors++; $display("FAIL edge_trig_addr: got %h expected 02", trig_addr_a); end
        checks++; if (last_k != 2) begin errors++; $display("FAIL edge_done_sample: got %0d expected 2", last_k); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL edge_done: got %b expected 1", done_a); end
        checks++; if (wr_addr_log.size() != 3) begin errors++; $display("FAIL edge_nwrites: got %0d expected 3", wr_addr_log.size()); end
    endtask

    // Stage0 bit0 rising x3, stage1 bit7 high.
    task automatic test_two_stage();
        set_cfg(24'h0, 24'h000005, 24'h200000, 16'd3, 16'd1, 3'd2, 8'd4);
        run_capture(0, 8'h00, 300);
        checks++; if (stage_hist[4] !== 2'd0) begin errors++; $display("FAIL two_stage_before: got %0d expected 0", stage_hist[4]); end
        checks++; if (stage_hist[5] !== 2'd1) begin errors++; $display("FAIL two_stage_adv: got %0d expected 1", stage_hist[5]); end
        checks++; if (trig_addr_a !== 8'h80) begin errors++; $display("FAIL two_trig_addr: got %h expected 80", trig_addr_a); end
        checks++; if (done_a !== 1'b1 || triggered_a !== 1'b1) begin errors++; $display("FAIL two_done: got done %b trig %b expected 1/1", done_a, triggered_a); end
    endtask

    // Store bit0 high only, trigger bit4 high (nr_stages 0 behaves as 1), post 2.
    task automatic test_store_mask();
        set_cfg(24'h000001, 24'h001000, 24'h0, 16'd1, 16'd0, 3'd0, 8'd2);
        run_capture(0, 8'h00, 100);
        checks++; if (wr_addr_log.size() != 11) begin errors++; $display("FAIL store_nwrites: got %0d expected 11", wr_addr_log.size()); end
        checks++; if (trig_addr_a !== 8'h08) begin errors++; $display("FAIL store_trig_addr: got %h expected 08", trig_addr_a); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL store_done: got %b expected 1", done_a); end
        if (wr_addr_log.size() == 11) begin
            checks++; if (wr_data_log[0] !== 8'h01 || wr_addr_log[0] !== 8'h00) begin errors++; $display("FAIL store_first: got addr %h data %h expected 00/01", wr_addr_log[0], wr_data_log[0]); end
            checks++; if (wr_data_log[8] !== 8'h10 || wr_addr_log[8] !== 8'h08) begin errors++; $display("FAIL store_trig_write: got addr %h data %h expected 08/10", wr_addr_log[8], wr_data_log[8]); end
            checks++; if (wr_data_log[9] !== 8'h11 || wr_data_log[10] !== 8'h13 || wr_addr_log[10] !== 8'h0A) begin errors++; $display("FAIL store_post: got %h %h at %h expected 11 13 at 0a", wr_data_log[9], wr_data_log[10], wr_addr_log[10]); end
        end
    endtask

    // DEPTH=16 instance: trigger on 0x28 (bits 5 and 3 high), post 3.
    task automatic test_wrap();
        set_cfg(24'h0, 24'h008200, 24'h0, 16'd1, 16'd0, 3'd1, 8'd3);
        run_capture(1, 8'h00, 100);
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", done_b); end
        checks++; if (full_b !== 1'b1) begin errors++; $display("FAIL wrap_full: got %b expected 1", full_b); end
        checks++; if (trig_addr_b !== 4'd8) begin errors++; $display("FAIL wrap_trig_addr: got %0d expected 8", trig_addr_b); end
        checks++; if (first_addr_b !== 4'd12) begin errors++; $display("FAIL wrap_first_addr: got %0d expected 12", first_addr_b); end
        checks++; if (wr_addr_log.size() != 44) begin errors++; $display("FAIL wrap_nwrites: got %0d expected 44", wr_addr_log.size()); end
        if (wr_addr_log.size() == 44) begin
            checks++; if (wr_addr_log[43] !== 8'h0B || wr_data_log[43] !== 8'h2B) begin errors++; $display("FAIL wrap_last_write: got addr %h data %h expected 0b/2b", wr_addr_log[43], wr_data_log[43]); end
        end
        checks++; if (full_a !== 1'b0 || trig_addr_a !== 8'h28) begin errors++; $display("FAIL wrap_big_dut: got full %b trig_addr %h expected 0/28", full_a, trig_addr_a); end
    endtask

    task automatic test_abort();
        set_cfg(24'h0, 24'h200000, 24'h0, 16'd1, 16'd0, 3'd1, 8'd4);
        run_capture(2, 8'h00, 300);
        checks++; if (triggered_a !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL abort_pre: got trig %b busy %b expected 1/1", triggered_a, busy_a); end
        signals_in = 8'h81;
        cmd_abort  = 1'b1;
        tick();
        cmd_abort  = 1'b0;
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b done %b expected 0/0", busy_a, done_a); end
        checks++; if (ram_wr_en_a !== 1'b0) begin errors++; $display("FAIL abort_wr_en: got %b expected 0", ram_wr_en_a); end
        signals_in = 8'h82;
        tick();
        checks++; if (ram_wr_en_a !== 1'b0) begin errors++; $display("FAIL abort_wr_en_later: got %b expected 0", ram_wr_en_a); end
        checks++; if (triggered_a !== 1'b1 || trig_addr_a !== 8'h80) begin errors++; $display("FAIL abort_keep: got trig %b addr %h expected 1/80", triggered_a, trig_addr_a); end
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        checks++; if (busy_a !== 1'b0 || triggered_a !== 1'b1) begin errors++; $display("FAIL abort_start: got busy %b trig %b expected 0/1", busy_a, triggered_a); end
    endtask

`ifdef ICETAP_TRIG_TIMEOUT_EN
    // Stage1 mask (bit0 and bit1 both rising) never matches a counter.
    task automatic test_timeout();
        set_cfg(24'h0, 24'h000005, 24'h00002D, 16'd1, 16'd1, 3'd2, 8'd0);
        cfg_stage_timeout = 16'd5;
        run_capture(3, 8'h00, 10);
        checks++; if (stage_hist[1] !== 2'd1) begin errors++; $display("FAIL to_adv: got %0d expected 1", stage_hist[1]); end
        checks++; if (stage_hist[5] !== 2'd1) begin errors++; $display("FAIL to_hold: got %0d expected 1", stage_hist[5]); end
        checks++; if (stage_hist[6] !== 2'd0) begin errors++; $display("FAIL to_expire: got %0d expected 0", stage_hist[6]); end
        checks++; if (stage_hist[7] !== 2'd1) begin errors++; $display("FAIL to_readv: got %0d expected 1", stage_hist[7]); end
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        cfg_stage_timeout = 16'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_stage();
        test_first_edge();
        test_two_stage();
        test_store_mask();
        test_wrap();
        test_abort();
`ifdef ICETAP_TRIG_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
